cell_bist_engine: RTL
=====================

# cell_bist_engine

Built-in self-test engine for the behavioural standard-cell library, used in iverilog regressions.
- Upstream: a maximal-length LFSR drives an 8-bit pattern bus into the cell array under test (buffers, inverters, and2/or2/xor2, mux2).
- Downstream: a 16-bit MISR compacts the array's combinational response.
- On completion, the final signature is compared against a golden value and a pass/fail verdict is latched.

## Interface

Parameters:
- NUM_PATTERNS, 255: patterns applied per run. Legal range 1..65535.
- SEED, 8'h01: LFSR load value at start. Must be nonzero.
- GOLDEN, 16'h0000: expected final MISR signature.

Ports:
- clk, input, 1: single clock; all state updates on its rising edge.
- rst_n, input, 1: reset; synchronous and active-low.
- start, input, 1: begin a run; level-sampled in IDLE or DONE, ignored in RUN.
- abort, input, 1: terminate a run; sampled in RUN only.
- resp_in, input, 8: response of the cell array to pat_out.
- pat_out, output, 8: pattern to the cell array.
- busy, output, 1: high while in RUN.
- done, output, 1: high while in DONE.
- pass, output, 1: verdict; valid while done=1.
- signature, output, 16: current MISR contents.
- pat_count, output, 16: number of patterns compacted so far in the current run.

## Operation

FSM states: IDLE, RUN, DONE.

Reset (rst_n=0 at an edge), regardless of state:
- state=IDLE, lfsr=SEED, signature=0, pat_count=0, done=0, pass=0, busy=0, pat_out=0.

IDLE:
- start=1 loads lfsr=SEED, signature=0, pat_count=0 and moves to RUN.

RUN:
- pat_out=lfsr.
- At each edge:
  - signature <= misr(signature, resp_in)
  - lfsr <= lfsr_next(lfsr)
  - pat_count <= pat_count+1
- If pat_count==NUM_PATTERNS-1 at that edge:
  - move to DONE
  - pass <= (misr(signature, resp_in) == GOLDEN), i.e. the compare uses the post-update signature.
- abort=1 has priority over the pattern update:
  - move to IDLE
  - lfsr, signature and pat_count hold their values
  - pass=0 and done stays 0

DONE:
- done=1; pass, signature and pat_count hold their values.
- pat_out=0.
- start=1 restarts with the same load as in IDLE and moves to RUN; done drops to 0 in that same edge.

In IDLE and DONE, pat_out=0.

LFSR (Fibonacci, x^8+x^6+x^5+x^4+1, period 255):
- lfsr_next = {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}.

MISR (CCITT polynomial 0x1021):
- misr(s,r) = ({s[14:0],1'b0} ^ (s[15] ? 16'h1021 : 16'h0000)) ^ {8'h00, r}.
- All arithmetic is modulo width. pat_count never exceeds NUM_PATTERNS.

## Timing

- The cell array is combinational. resp_in is sampled at the same edge that ends the cycle in which the matching pat_out is presented, so there is no extra response latency.
- Start at edge E0:
  - RUN occupies cycles 1..NUM_PATTERNS.
  - busy=1 in exactly those cycles.
  - done=1 from cycle NUM_PATTERNS+1 onward.
- Latency from start to done is NUM_PATTERNS+1 edges.
- start and abort arriving in the same cycle:
  - In RUN, abort wins (start is ignored there).
  - In IDLE or DONE, start wins (abort is ignored there).
- Abort on the final pattern edge also wins: no DONE, pass=0.
- NUM_PATTERNS > 255: the pattern sequence wraps. Pattern k+255 equals pattern k.
- Reset asserted mid-RUN takes effect at the next edge. No partial verdict is retained.

## Test plan

- resp_in tied to pat_out, NUM_PATTERNS=1, SEED=01, GOLDEN=0001: pulse start -> one busy cycle with pat_out=01; then done=1, signature=0001, pass=1, pat_count=1.
- Same setup with NUM_PATTERNS=2, GOLDEN=0000 -> pat_out sequence 01, 02; signature=0000; pass=1; done asserted at 3 edges after start.
- resp_in=~pat_out, NUM_PATTERNS=1, GOLDEN=0001 -> signature=00FE, pass=0, done=1.
- NUM_PATTERNS=256, resp_in tied to pat_out -> pat_out on pattern 256 equals 01; no pattern value is 00; pat_count=256 at done; signature matches the reference model.
- Abort at pattern 5 of 10 -> busy falls at the next edge; done=0, pass=0, pat_count=5. A following start runs all 10 patterns to done, with signature equal to an uninterrupted run.
- rst_n=0 for one edge mid-RUN -> all outputs at reset values the next cycle. start in the same cycle as rst_n=0 is ignored.

Source files
------------

// File: rtl/cell_bist_engine.sv
// cell_bist_engine: LFSR pattern source, MISR response compactor and
// a latched pass/fail verdict for the standard-cell array under test.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   start      begin a run (sampled in IDLE/DONE)
//   abort      cancel a run (sampled in RUN)
//   resp_in    combinational response of the array to pat_out
//   pat_out    pattern to the array (0 outside RUN)
//   busy       high in RUN
//   done       high in DONE
//   pass       verdict, valid while done=1
//   signature  current MISR contents
//   pat_count  patterns compacted in the current run
module cell_bist_engine #(
    parameter int          NUM_PATTERNS = 255,
    parameter logic [7:0]  SEED         = 8'h01,
    parameter logic [15:0] GOLDEN       = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [7:0]  resp_in,
    output logic [7:0]  pat_out,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] signature,
    output logic [15:0] pat_count
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [15:0] LAST = 16'(NUM_PATTERNS - 1);

    logic [1:0]  state_q, state_d;
    logic [7:0]  lfsr_q, lfsr_d;
    logic [15:0] sig_q, sig_d;
    logic [15:0] cnt_q, cnt_d;
    logic        pass_q, pass_d;

    logic [7:0]  lfsr_nxt;
    logic [15:0] misr_nxt;

    // x^8+x^6+x^5+x^4+1 Fibonacci step
    assign lfsr_nxt = {lfsr_q[6:0],
                       lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

    // CCITT 0x1021 shift with the response folded into the low byte
    assign misr_nxt = ({sig_q[14:0], 1'b0}
                       ^ (sig_q[15] ? 16'h1021 : 16'h0000))
                      ^ {8'h00, resp_in};

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        sig_d   = sig_q;
        cnt_d   = cnt_q;
        pass_d  = pass_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_RUN;
                    lfsr_d  = SEED;
                    sig_d   = 16'h0000;
                    cnt_d   = 16'h0000;
                    pass_d  = 1'b0;
                end
            end
            S_RUN: begin
                // abort freezes the datapath; only the verdict is cleared
                if (abort) begin
                    state_d = S_IDLE;
                    pass_d  = 1'b0;
                end else begin
                    sig_d  = misr_nxt;
                    lfsr_d = lfsr_nxt;
                    cnt_d  = cnt_q + 16'd1;
                    if (cnt_q == LAST) begin
                        state_d = S_DONE;
                        pass_d  = (misr_nxt == GOLDEN);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            lfsr_q  <= SEED;
            sig_q   <= 16'h0000;
            cnt_q   <= 16'h0000;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            sig_q   <= sig_d;
            cnt_q   <= cnt_d;
            pass_q  <= pass_d;
        end
    end

    assign busy      = (state_q == S_RUN);
    assign done      = (state_q == S_DONE);
    assign pass      = pass_q;
    assign signature = sig_q;
    assign pat_count = cnt_q;
    assign pat_out   = busy ? lfsr_q : 8'h00;

endmodule
